// File: rtl/rename_pkg.sv
// Shared rename-stage types: physical register sizing, free-list
// pointer types and the free-list controller state encoding.
package rename_pkg;

   localparam int NUM_PREG  = 64;
   localparam int ARCH_REGS = 32;
   localparam int PREG_W    = $clog2(NUM_PREG);
   localparam int NUM_FREE  = NUM_PREG - ARCH_REGS;
   localparam int FIDX_W    = $clog2(NUM_FREE);
   localparam int PTR_W     = FIDX_W + 1;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PTR_W-1:0]  fptr_t;

   typedef enum logic [1:0] {
      FL_INIT,
      FL_RUN,
      FL_RECOVER
   } fl_state_t;

endpackage

// File: rtl/popcnt4.sv
// 4-bit population count with exclusive prefix counts per lane
// (pre<i> = number of set bits below lane i).
module popcnt4 (
   input  logic [3:0] v,
   output logic [1:0] pre1,
   output logic [1:0] pre2,
   output logic [1:0] pre3,
   output logic [2:0] cnt
);

   assign pre1 = {1'b0, v[0]};
   assign pre2 = pre1 + {1'b0, v[1]};
   assign pre3 = pre2 + {1'b0, v[2]};
   assign cnt  = {1'b0, pre3} + {2'b0, v[3]};

endmodule

// File: rtl/freelist_ctrl.sv
// 4-wide physical-register free list with speculative and architectural
// heads. Define FREELIST_CHECK_EN to build the sticky err checker.
module freelist_ctrl
   import rename_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        alloc_req,
   output logic              alloc_ready,
   output logic [PREG_W-1:0] alloc_preg0,
   output logic [PREG_W-1:0] alloc_preg1,
   output logic [PREG_W-1:0] alloc_preg2,
   output logic [PREG_W-1:0] alloc_preg3,
   input  logic [3:0]        commit_alloc,
   input  logic [3:0]        free_valid,
   input  logic [PREG_W-1:0] free_preg0,
   input  logic [PREG_W-1:0] free_preg1,
   input  logic [PREG_W-1:0] free_preg2,
   input  logic [PREG_W-1:0] free_preg3,
   input  logic              flush,
   output logic [PTR_W-1:0]  free_cnt,
   output logic              err
);

   fl_state_t         state_q, state_d;
   logic [FIDX_W-3:0] init_q;
   fptr_t             spec_head, arch_head, tail, arch_nxt;
   preg_t             mem [NUM_FREE];
   preg_t             fpreg [4];
   preg_t             apreg [4];
   logic [1:0]        rq_pre [4];
   logic [1:0]        fv_pre [4];
   logic [2:0]        rq_cnt, fv_cnt, ca_cnt;
   logic [1:0]        ca_pre1, ca_pre2, ca_pre3;
   logic              ca_unused;
   logic [FIDX_W-1:0] rd_idx [4];
   logic [FIDX_W-1:0] wr_idx [4];
   logic              alloc_fire;

   popcnt4 u_pc_req (
      .v    (alloc_req),
      .pre1 (rq_pre[1]),
      .pre2 (rq_pre[2]),
      .pre3 (rq_pre[3]),
      .cnt  (rq_cnt)
   );

   popcnt4 u_pc_free (
      .v    (free_valid),
      .pre1 (fv_pre[1]),
      .pre2 (fv_pre[2]),
      .pre3 (fv_pre[3]),
      .cnt  (fv_cnt)
   );

   popcnt4 u_pc_commit (
      .v    (commit_alloc),
      .pre1 (ca_pre1),
      .pre2 (ca_pre2),
      .pre3 (ca_pre3),
      .cnt  (ca_cnt)
   );

   assign rq_pre[0] = 2'd0;
   assign fv_pre[0] = 2'd0;
   assign ca_unused = ^{ca_pre1, ca_pre2, ca_pre3};

   assign fpreg[0] = free_preg0;
   assign fpreg[1] = free_preg1;
   assign fpreg[2] = free_preg2;
   assign fpreg[3] = free_preg3;

   assign free_cnt    = tail - spec_head;
   assign arch_nxt    = arch_head + fptr_t'(ca_cnt);
   assign alloc_ready = (state_q == FL_RUN) && (free_cnt >= fptr_t'(4));
   assign alloc_fire  = alloc_ready && (|alloc_req) && !flush;

   // Unrequested slots still read their computed entry; outputs are 0 in INIT.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rd_idx[i] = FIDX_W'(spec_head + fptr_t'(rq_pre[i]));
         wr_idx[i] = FIDX_W'(tail + fptr_t'(fv_pre[i]));
         apreg[i]  = (state_q == FL_INIT) ? '0 : mem[rd_idx[i]];
      end
   end

   assign alloc_preg0 = apreg[0];
   assign alloc_preg1 = apreg[1];
   assign alloc_preg2 = apreg[2];
   assign alloc_preg3 = apreg[3];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FL_INIT:    if (init_q == '1) state_d = FL_RUN;
         FL_RUN:     if (flush) state_d = FL_RECOVER;
         FL_RECOVER: state_d = FL_RUN;
         default:    state_d = FL_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FL_INIT;
         init_q    <= '0;
         spec_head <= '0;
         arch_head <= '0;
         tail      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FL_INIT) begin
            init_q <= init_q + 1'b1;
            // Wrap bit set with index 0: list is full on leaving INIT.
            if (init_q == '1) tail <= fptr_t'(NUM_FREE);
         end else begin
            tail      <= tail + fptr_t'(fv_cnt);
            arch_head <= arch_nxt;
            if (state_q == FL_RUN && flush)
               spec_head <= arch_nxt;
            else if (alloc_fire)
               spec_head <= spec_head + fptr_t'(rq_cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == FL_INIT) begin
            for (int k = 0; k < 4; k++)
               mem[{init_q, k[1:0]}] <= preg_t'(ARCH_REGS)
                                      + preg_t'({init_q, k[1:0]});
         end else begin
            for (int i = 0; i < 4; i++)
               if (free_valid[i]) mem[wr_idx[i]] <= fpreg[i];
         end
      end
   end

`ifdef FREELIST_CHECK_EN
   fptr_t occ_nxt, lead_nxt;
   logic  err_q, bad_free, bad_commit, bad_req;

   assign occ_nxt    = tail + fptr_t'(fv_cnt) - arch_nxt;
   assign lead_nxt   = spec_head - arch_nxt;
   assign bad_free   = occ_nxt > fptr_t'(NUM_FREE);
   assign bad_commit = lead_nxt > fptr_t'(NUM_FREE);
   assign bad_req    = (state_q == FL_RUN) && (|alloc_req)
                    && !alloc_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if (state_q != FL_INIT && (bad_free || bad_commit || bad_req))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed self-checking bench for freelist_ctrl: init, grants, stall,
// flush recovery and a free/allocate cycle across the wrap boundary.
module tb_freelist_ctrl;
   import rename_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        alloc_req;
   logic              alloc_ready;
   logic [PREG_W-1:0] alloc_preg0, alloc_preg1, alloc_preg2, alloc_preg3;
   logic [3:0]        commit_alloc;
   logic [3:0]        free_valid;
   logic [PREG_W-1:0] free_preg0, free_preg1, free_preg2, free_preg3;
   logic              flush;
   logic [PTR_W-1:0]  free_cnt;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;

   freelist_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_ready  (alloc_ready),
      .alloc_preg0  (alloc_preg0),
      .alloc_preg1  (alloc_preg1),
      .alloc_preg2  (alloc_preg2),
      .alloc_preg3  (alloc_preg3),
      .commit_alloc (commit_alloc),
      .free_valid   (free_valid),
      .free_preg0   (free_preg0),
      .free_preg1   (free_preg1),
      .free_preg2   (free_preg2),
      .free_preg3   (free_preg3),
      .flush        (flush),
      .free_cnt     (free_cnt),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_req    = '0;
      commit_alloc = '0;
      free_valid   = '0;
      flush        = 1'b0;
      free_preg0   = '0;
      free_preg1   = '0;
      free_preg2   = '0;
      free_preg3   = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      check("init_cnt", free_cnt, 0);
      check("init_rdy", alloc_ready, 0);
      check("init_preg", alloc_preg0, 0);
      check("init_err", err, 0);
      repeat (7) step();
      check("init_rdy_late", alloc_ready, 0);
      step();
      check("run_cnt", free_cnt, 32);
      check("run_rdy", alloc_ready, 1);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      do_reset();

      alloc_req = 4'b1111;
      #1;
      check("g4_p0", alloc_preg0, 32);
      check("g4_p1", alloc_preg1, 33);
      check("g4_p2", alloc_preg2, 34);
      check("g4_p3", alloc_preg3, 35);
      step();
      check("g4_cnt", free_cnt, 28);

      alloc_req = 4'b1010;
      #1;
      check("g2_p1", alloc_preg1, 36);
      check("g2_p3", alloc_preg3, 37);
      step();
      check("g2_cnt", free_cnt, 26);

      repeat (5) begin
         alloc_req = 4'b1111;
         step();
      end
      alloc_req = 4'b0111;
      step();
      alloc_req = '0;
      #1;
      check("low_cnt", free_cnt, 3);
      check("low_rdy", alloc_ready, 0);

      alloc_req  = 4'b0001;
      free_valid = 4'b0001;
      free_preg0 = 6'd9;
      #1;
      check("free_same_rdy", alloc_ready, 0);
      step();
      idle();
      #1;
      check("free_next_cnt", free_cnt, 4);
      check("free_next_rdy", alloc_ready, 1);
      check("free_next_p0", alloc_preg0, 61);

      do_reset();
      alloc_req = 4'b1111;
      step();
      step();
      alloc_req = '0;
      #1;
      check("pre_fl_cnt", free_cnt, 24);
      alloc_req    = 4'b1111;
      commit_alloc = 4'b0111;
      flush        = 1'b1;
      step();
      idle();
      alloc_req = 4'b1111;
      #1;
      check("rec_rdy", alloc_ready, 0);
      check("rec_cnt", free_cnt, 29);
      step();
      #1;
      check("post_rdy", alloc_ready, 1);
      check("post_cnt", free_cnt, 29);
      check("post_p0", alloc_preg0, 35);
      check("post_p3", alloc_preg3, 38);
      step();
      alloc_req = '0;
      #1;
      check("post_alloc_cnt", free_cnt, 25);

      do_reset();
      repeat (7) begin
         alloc_req = 4'b1111;
         step();
      end
      alloc_req    = 4'b0011;
      commit_alloc = 4'b0011;
      free_valid   = 4'b0011;
      free_preg0   = 6'd1;
      free_preg1   = 6'd2;
      step();
      for (int j = 0; j < 7; j++) begin
         alloc_req    = 4'b1111;
         commit_alloc = 4'b1111;
         free_valid   = 4'b1111;
         free_preg0   = 6'(4 * j + 3);
         free_preg1   = 6'(4 * j + 4);
         free_preg2   = 6'(4 * j + 5);
         free_preg3   = 6'(4 * j + 6);
         step();
      end
      idle();
      #1;
      check("wrap_pre_cnt", free_cnt, 4);

      alloc_req    = 4'b1111;
      commit_alloc = 4'b1111;
      free_valid   = 4'b1111;
      free_preg0   = 6'd60;
      free_preg1   = 6'd61;
      free_preg2   = 6'd62;
      free_preg3   = 6'd63;
      #1;
      check("wrap_g_p0", alloc_preg0, 27);
      check("wrap_g_p3", alloc_preg3, 30);
      step();
      idle();
      #1;
      check("wrap_cnt", free_cnt, 4);
      alloc_req = 4'b1111;
      #1;
      check("wrap_p0", alloc_preg0, 60);
      check("wrap_p1", alloc_preg1, 61);
      check("wrap_p2", alloc_preg2, 62);
      check("wrap_p3", alloc_preg3, 63);
      check("end_err", err, 0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
